mem_stage_access_unit: RTL and testbench
========================================

Name: mem_stage_access_unit

Overview:
- MEM-stage initiator for the pipelined MIPS core.
- Takes EX/MEM-register load/store requests and drives the data-memory port (address, write_data, mem_read, mem_write).
- Waits for a memory-ready handshake, stalls the pipeline while an access is outstanding, and presents a registered MEM/WB result (load data or pass-through ALU result).
- Flags misaligned, out-of-range and timed-out accesses.

Parameters:
- MEM_WORDS, 30, number of 32-bit words in data memory; word index ≥ MEM_WORDS is out of range.
- TIMEOUT, 15, max cycles in ACCESS waiting for mem_ready before abort (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM register holds a valid instruction.
- in_load  in  1  instruction is lw.
- in_store  in  1  instruction is sw.
- in_addr  in  32  byte address from ALU.
- in_wdata  in  32  store data.
- in_alu_result  in  32  result passed through for non-load instructions.
- in_rd  in  5  destination register.
- in_regwrite  in  1  instruction writes a register.
- stall  out  1  upstream must hold the EX/MEM register.
- mem_address  out  32  word index to data memory.
- mem_write_data  out  32  store data to memory.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_read_data  in  32  read data from memory.
- mem_ready  in  1  memory has completed the current request.
- wb_valid  out  1  MEM/WB register valid.
- wb_data  out  32  load data or ALU result.
- wb_rd  out  5  destination register.
- wb_regwrite  out  1  write-back enable; 0 for stores and faulted ops.
- fault  out  1  one-cycle pulse with wb_valid on a faulted access.
- load_count  out  32  perf counter (see Optional Feature).
- store_count  out  32  perf counter.
- stall_cycles  out  32  perf counter.

Behaviour:
Reset:
- Asynchronous, active-high. State=IDLE.
- All outputs 0: stall, mem_read, mem_write, mem_address, mem_write_data, wb_*, fault, all counters.
- Reset mid-ACCESS drops mem_read/mem_write immediately and discards the request. No write-back occurs.

States:
- IDLE: accepts in_valid.
- ACCESS: request outstanding.

IDLE, in_valid=1:
- Neither in_load nor in_store: next cycle wb_valid=1, wb_data=in_alu_result, wb_rd/wb_regwrite copied, fault=0. Latency 1. No stall.
- Load xor store, with in_addr[1:0]==0 and in_addr[31:2] < MEM_WORDS:
  - Latch request. mem_address=in_addr>>2, mem_write_data=in_wdata.
  - mem_read=in_load, mem_write=in_store, all registered.
  - Go to ACCESS. wb_valid=0 next cycle.
- Misaligned, out of range, or in_load&&in_store:
  - No memory request.
  - Next cycle wb_valid=1, fault=1, wb_regwrite=0, wb_data=0.

ACCESS:
- stall=1 (decoded from state only, no combinational path from inputs).
- in_* ignored. Request signals held stable.
- Internal wait counter increments from 0 each cycle.
- On a rising edge with mem_ready=1:
  - Drop mem_read/mem_write. Return to IDLE.
  - Next cycle wb_valid=1.
  - Load: wb_data=mem_read_data sampled that edge, wb_regwrite=latched in_regwrite.
  - Store: wb_regwrite=0, wb_data=0.
  - Minimum access latency 2 cycles (accept→ACCESS→IDLE).
- Wait counter reaches TIMEOUT without mem_ready:
  - Drop request, go IDLE.
  - wb_valid=1, fault=1, wb_regwrite=0.
- mem_ready while in IDLE is ignored.

Other rules:
- wb_valid and fault are single-cycle pulses per instruction.
- wb_* holds its last value when wb_valid=0.
- Back-to-back instructions: the instruction presented during ACCESS is accepted in the IDLE cycle after stall falls.

Optional Feature:
Macro MEM_PERF_CNT_EN.
- Defined:
  - load_count increments on each completed (non-fault) load.
  - store_count increments on each completed store.
  - stall_cycles increments on every cycle stall=1.
  - All three are 32-bit and wrap modulo 2^32; reset clears them.
- Undefined: the three ports are tied to 0 and no counter logic is built.

Test Plan:
- Load, memory ready one cycle after request: lw addr 0x10 (word 4); memory returns 5 with mem_ready one cycle after request → mem_address=4, mem_read=1 for 1 cycle, stall=1 for 1 cycle, then wb_valid=1, wb_data=5, wb_regwrite=1.
- Store with 3-cycle wait: sw addr 0x48 (word 18), data 0x2A; mem_ready after 3 cycles → mem_write=1 with mem_address=18, mem_write_data=0x2A held 3 cycles; wb_regwrite=0; store_count=1 with MEM_PERF_CNT_EN.
- Address faults: lw addr 0x12 (misaligned) and lw addr 0x78 (word 30, out of range) → no mem_read asserted; next cycle wb_valid=1, fault=1, wb_regwrite=0.
- Timeout: lw with mem_ready held 0, TIMEOUT=15 → request held 15 cycles then dropped; fault=1; stall_cycles=15.
- Back-to-back: add (alu_result 7) then lw word 2 (memory returns 3) then add (alu_result 9) → wb sequence 7, 3, 9; third instruction held by stall and accepted only after stall falls.
- Reset mid-ACCESS: reset asserted asynchronously during ACCESS → mem_read=0 immediately; no wb_valid after release; the next lw completes normally.

Source files
------------

// File: rtl/mem_stage_access_unit.sv
// mem_stage_access_unit: MEM-stage load/store initiator for the pipelined MIPS core.
// Accepts EX/MEM requests, drives the data-memory port with a ready handshake,
// stalls upstream while an access is outstanding and produces a registered MEM/WB
// result. Misaligned, out-of-range, load+store and timed-out accesses raise fault.
// Optional performance counters are built when MEM_PERF_CNT_EN is defined;
// otherwise load_count/store_count/stall_cycles are tied to zero.
module mem_stage_access_unit #(
    parameter int MEM_WORDS = 30,
    parameter int TIMEOUT   = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_alu_result,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    output logic        stall,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic        fault,
    output logic [31:0] load_count,
    output logic [31:0] store_count,
    output logic [31:0] stall_cycles
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               acc_load;
    logic [4:0]         acc_rd;
    logic               acc_regwrite;

    logic               is_mem;
    logic               addr_ok;
    logic               req_ok;

    // Request classification: a memory op is legal only if exactly one of
    // load/store is set and the word address is aligned and inside memory.
    assign is_mem  = in_load | in_store;
    assign addr_ok = (in_addr[1:0] == 2'b00) &&
                     ({2'b00, in_addr[31:2]} < 32'(MEM_WORDS));
    assign req_ok  = (in_load ^ in_store) && addr_ok;

    // Stall comes straight from the state register, never from inputs.
    assign stall = (state == ACCESS);

    // Main FSM: request launch, handshake/timeout tracking and MEM/WB register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            acc_load       <= 1'b0;
            acc_rd         <= '0;
            acc_regwrite   <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            wb_valid       <= 1'b0;
            wb_data        <= '0;
            wb_rd          <= '0;
            wb_regwrite    <= 1'b0;
            fault          <= 1'b0;
        end else begin
            // wb_valid/fault are pulses; wb_data/rd/regwrite hold otherwise.
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem) begin
                            wb_valid    <= 1'b1;
                            wb_data     <= in_alu_result;
                            wb_rd       <= in_rd;
                            wb_regwrite <= in_regwrite;
                        end else if (req_ok) begin
                            mem_address    <= {2'b00, in_addr[31:2]};
                            mem_write_data <= in_wdata;
                            mem_read       <= in_load;
                            mem_write      <= in_store;
                            acc_load       <= in_load;
                            acc_rd         <= in_rd;
                            acc_regwrite   <= in_regwrite;
                            wait_cnt       <= '0;
                            state          <= ACCESS;
                        end else begin
                            wb_valid    <= 1'b1;
                            fault       <= 1'b1;
                            wb_data     <= '0;
                            wb_rd       <= in_rd;
                            wb_regwrite <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= IDLE;
                        wb_valid  <= 1'b1;
                        wb_rd     <= acc_rd;
                        if (acc_load) begin
                            wb_data     <= mem_read_data;
                            wb_regwrite <= acc_regwrite;
                        end else begin
                            wb_data     <= '0;
                            wb_regwrite <= 1'b0;
                        end
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // TIMEOUT cycles spent in ACCESS with no ready: abort.
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        state       <= IDLE;
                        wb_valid    <= 1'b1;
                        fault       <= 1'b1;
                        wb_data     <= '0;
                        wb_rd       <= acc_rd;
                        wb_regwrite <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_PERF_CNT_EN
    // Performance counters: completed loads/stores and cycles spent stalling.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_count   <= '0;
            store_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (state == ACCESS) begin
                stall_cycles <= stall_cycles + 32'd1;
                if (mem_ready) begin
                    if (acc_load) load_count  <= load_count + 32'd1;
                    else          store_count <= store_count + 32'd1;
                end
            end
        end
    end
`else
    assign load_count   = '0;
    assign store_count  = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed testbench for mem_stage_access_unit (MEM_WORDS=30, TIMEOUT=15).
// Counter expectations follow MEM_PERF_CNT_EN: zero when the macro is undefined.
module tb_mem_stage_access_unit;

`ifdef MEM_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_load, in_store, in_regwrite;
    logic [31:0] in_addr, in_wdata, in_alu_result;
    logic [4:0]  in_rd;
    logic        stall, mem_read, mem_write, mem_ready;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        wb_valid, wb_regwrite, fault;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [31:0] load_count, store_count, stall_cycles;

    int vectors = 0;
    int errors  = 0;

    mem_stage_access_unit #(.MEM_WORDS(30), .TIMEOUT(15)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_load        (in_load),
        .in_store       (in_store),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_alu_result  (in_alu_result),
        .in_rd          (in_rd),
        .in_regwrite    (in_regwrite),
        .stall          (stall),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_regwrite    (wb_regwrite),
        .fault          (fault),
        .load_count     (load_count),
        .store_count    (store_count),
        .stall_cycles   (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 0; in_load = 0; in_store = 0; in_regwrite = 0;
        in_addr = 0; in_wdata = 0; in_alu_result = 0; in_rd = 0;
    endtask

    task automatic present(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] alu,
                           input logic [4:0] rd, input logic rw);
        in_valid = 1; in_load = ld; in_store = st; in_addr = addr;
        in_wdata = wdata; in_alu_result = alu; in_rd = rd; in_regwrite = rw;
    endtask

    task automatic chk_counters(input string tag, input int nl, input int ns, input int nc);
        chk({tag, "_load_count"},   load_count,   PERF ? 32'(nl) : 32'd0);
        chk({tag, "_store_count"},  store_count,  PERF ? 32'(ns) : 32'd0);
        chk({tag, "_stall_cycles"}, stall_cycles, PERF ? 32'(nc) : 32'd0);
    endtask

    initial begin
        reset = 1; mem_ready = 0; mem_read_data = 0;
        clear_in();
        repeat (2) @(posedge clock);
        #1;
        // Reset state
        chk("rst_stall", stall, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_fault", fault, 0);
        chk_counters("rst", 0, 0, 0);
        reset = 0;
        step();

        // Load, ready one cycle after request: word 4 returns 5
        present(1, 0, 32'h10, 0, 0, 5'd3, 1);
        step();
        clear_in();
        chk("ld_mem_read", mem_read, 1);
        chk("ld_mem_address", mem_address, 4);
        chk("ld_stall", stall, 1);
        chk("ld_wb_valid_busy", wb_valid, 0);
        mem_ready = 1; mem_read_data = 32'd5;
        step();
        mem_ready = 0; mem_read_data = 0;
        chk("ld_mem_read_drop", mem_read, 0);
        chk("ld_stall_drop", stall, 0);
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_data", wb_data, 5);
        chk("ld_wb_rd", wb_rd, 3);
        chk("ld_wb_regwrite", wb_regwrite, 1);
        chk("ld_fault", fault, 0);
        step();
        chk("ld_wb_valid_pulse", wb_valid, 0);
        chk("ld_wb_data_hold", wb_data, 5);
        chk_counters("ld", 1, 0, 1);

        // Store with three-cycle wait: word 18, data 0x2A
        present(0, 1, 32'h48, 32'h2A, 0, 5'd4, 1);
        step();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            chk("st_mem_write", mem_write, 1);
            chk("st_mem_read", mem_read, 0);
            chk("st_mem_address", mem_address, 18);
            chk("st_mem_write_data", mem_write_data, 32'h2A);
            chk("st_stall", stall, 1);
            if (i == 2) mem_ready = 1;
            step();
        end
        mem_ready = 0;
        chk("st_mem_write_drop", mem_write, 0);
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_regwrite", wb_regwrite, 0);
        chk("st_wb_data", wb_data, 0);
        chk("st_fault", fault, 0);
        chk_counters("st", 1, 1, 4);

        // Address faults: misaligned, out of range, load+store together
        present(1, 0, 32'h12, 0, 0, 5'd4, 1);
        step();
        chk("mis_mem_read", mem_read, 0);
        chk("mis_stall", stall, 0);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_fault", fault, 1);
        chk("mis_wb_regwrite", wb_regwrite, 0);
        chk("mis_wb_data", wb_data, 0);
        present(1, 0, 32'h78, 0, 0, 5'd4, 1);
        step();
        chk("oor_mem_read", mem_read, 0);
        chk("oor_stall", stall, 0);
        chk("oor_wb_valid", wb_valid, 1);
        chk("oor_fault", fault, 1);
        chk("oor_wb_regwrite", wb_regwrite, 0);
        present(1, 1, 32'h0, 0, 0, 5'd4, 1);
        step();
        clear_in();
        chk("ldst_mem_read", mem_read, 0);
        chk("ldst_mem_write", mem_write, 0);
        chk("ldst_fault", fault, 1);
        chk("ldst_wb_regwrite", wb_regwrite, 0);
        step();
        chk("flt_fault_pulse", fault, 0);
        chk("flt_wb_valid_pulse", wb_valid, 0);
        chk_counters("flt", 1, 1, 4);

        // Timeout: ready never comes, request held 15 cycles
        present(1, 0, 32'h0, 0, 0, 5'd2, 1);
        step();
        clear_in();
        for (int i = 0; i < 15; i++) begin
            chk("to_mem_read_held", mem_read, 1);
            chk("to_stall_held", stall, 1);
            chk("to_wb_valid_busy", wb_valid, 0);
            step();
        end
        chk("to_mem_read_drop", mem_read, 0);
        chk("to_stall_drop", stall, 0);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_fault", fault, 1);
        chk("to_wb_regwrite", wb_regwrite, 0);
        chk_counters("to", 1, 1, 19);
        step();
        chk("to_fault_pulse", fault, 0);

        // Back-to-back: add(7), lw word 2 (returns 3), add(9) held by stall
        present(0, 0, 0, 0, 32'd7, 5'd5, 1);
        step();
        chk("b2b_add1_valid", wb_valid, 1);
        chk("b2b_add1_data", wb_data, 7);
        chk("b2b_add1_rd", wb_rd, 5);
        chk("b2b_add1_stall", stall, 0);
        present(1, 0, 32'h8, 0, 0, 5'd6, 1);
        step();
        chk("b2b_lw_mem_read", mem_read, 1);
        chk("b2b_lw_address", mem_address, 2);
        chk("b2b_lw_stall", stall, 1);
        chk("b2b_lw_wb_valid", wb_valid, 0);
        present(0, 0, 0, 0, 32'd9, 5'd7, 1);
        mem_ready = 1; mem_read_data = 32'd3;
        step();
        mem_ready = 0; mem_read_data = 32'hFFFF_FFFF;
        chk("b2b_lw_valid", wb_valid, 1);
        chk("b2b_lw_data", wb_data, 3);
        chk("b2b_lw_rd", wb_rd, 6);
        chk("b2b_lw_stall_drop", stall, 0);
        step();
        clear_in();
        chk("b2b_add2_valid", wb_valid, 1);
        chk("b2b_add2_data", wb_data, 9);
        chk("b2b_add2_rd", wb_rd, 7);
        step();
        chk("b2b_idle_valid", wb_valid, 0);
        chk_counters("b2b", 2, 1, 20);

        // Asynchronous reset during ACCESS
        present(1, 0, 32'h4, 0, 0, 5'd8, 1);
        step();
        clear_in();
        chk("rma_mem_read_pre", mem_read, 1);
        #2;
        reset = 1;
        #1;
        chk("rma_mem_read_async", mem_read, 0);
        chk("rma_stall_async", stall, 0);
        chk("rma_address_async", mem_address, 0);
        step();
        reset = 0;
        mem_ready = 1;
        step();
        mem_ready = 0;
        chk("rma_wb_valid_after", wb_valid, 0);
        chk("rma_mem_read_after", mem_read, 0);
        chk_counters("rma", 0, 0, 0);
        present(1, 0, 32'h14, 0, 0, 5'd9, 1);
        step();
        clear_in();
        chk("rma_next_mem_read", mem_read, 1);
        chk("rma_next_address", mem_address, 5);
        mem_ready = 1; mem_read_data = 32'hDEAD_BEEF;
        step();
        mem_ready = 0;
        chk("rma_next_wb_valid", wb_valid, 1);
        chk("rma_next_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("rma_next_wb_rd", wb_rd, 9);
        chk("rma_next_wb_regwrite", wb_regwrite, 1);
        chk_counters("rma_next", 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
